instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Write-side counterpart of the main control decoder. It accepts decoded instruction fields (operation select plus register, immediate and target fields) over a valid/ready handshake and packs them into 32-bit MIPS words using the same opcode map the decoder consumes. It then writes each word sequentially into instruction memory through a single-port write interface. It sits between the testbench or boot loader and the instruction memory, and is used to load programs before the CPU is released from reset.

Parameters:
ADDR_W, 32, width of Mem_Addr (byte address)
DEPTH, 256, instruction memory capacity in words; must be ≥1
BASE_ADDR, 0, byte address of the first word written after reset or Clear; must be 4-aligned

Ports:
Clk  input  1  rising-edge clock
Rst_N  input  1  reset, synchronous, active-low
Clear  input  1  synchronous restart: pointer to BASE_ADDR, count and Err cleared
In_Valid  input  1  instruction fields valid
In_Ready  output  1  encoder can accept fields
Op_Sel  input  5  operation: 0 RTYPE, 1 LW, 2 SW, 3 ADDI, 4 ANDI, 5 ORI, 6 SLTI, 7 XORI, 8 BNE, 9 BEQ, 10 J, 11 JAL, 12 LUI, 13 LB, 14 LH, 15 SB, 16 SH; 17-31 illegal
Rs  input  5  source register
Rt  input  5  target register
Rd  input  5  destination register (RTYPE only)
Shamt  input  5  shift amount (RTYPE only)
Funct  input  6  function code (RTYPE only)
Imm  input  16  immediate / branch offset, passed raw
Target  input  26  jump target field
Mem_Write_En  output  1  one-cycle write strobe
Mem_Addr  output  ADDR_W  byte address of the word being written
Mem_Write_Data  output  32  encoded instruction word
Word_Count  output  $clog2(DEPTH+1)  words written since reset/Clear
Full  output  1  Word_Count == DEPTH
Err  output  1  sticky: an illegal Op_Sel was accepted

Behaviour:
- Reset (Rst_N low at a rising edge) has highest priority. Reset values: state IDLE, In_Ready 0 during reset then 1, Mem_Write_En 0, Mem_Addr BASE_ADDR, Mem_Write_Data 0, Word_Count 0, Full 0, Err 0.
- Clear is second priority. It applies the same values as reset in any state and aborts a pending ENCODE/WRITE, so no write strobe is issued.
- FSM states:
  - IDLE: In_Ready = !Full. On In_Valid & In_Ready (cycle T), all fields are captured into registers and the FSM goes to ENCODE. The captured fields are independent of later input changes.
  - ENCODE (T+1): the word is built into Mem_Write_Data. For an illegal Op_Sel, Err is set, no write occurs, the pointer is unchanged, and the FSM returns to IDLE. Otherwise the FSM goes to WRITE.
  - WRITE (T+2): Mem_Write_En = 1 for exactly this cycle, with Mem_Addr = current pointer. At the end of the cycle the pointer increments by 4 and Word_Count by 1. The FSM then returns to IDLE.
- In_Ready is 0 in ENCODE and WRITE. It reasserts at T+3 unless Full. Throughput is one word per 3 cycles; write latency is 2 cycles from acceptance.
- Encoding rules (opcode values):
  - RTYPE = {6'd0, Rs, Rt, Rd, Shamt, Funct}.
  - I-type = {op, Rs, Rt, Imm}, where op = LW 35, SW 43, ADDI 8, ANDI 12, ORI 13, SLTI 10, XORI 14, BNE 5, BEQ 4, LUI 15, LB 32, LH 33, SB 40, SH 41.
  - LUI forces the Rs field to 0.
  - J-type = {op, Target}, with J 2 and JAL 3.
  - Unused input fields are ignored.
- Full boundary: after the DEPTH-th write, Full = 1 and In_Ready = 0 until Clear or reset. In_Valid while Full is ignored, not an error. Mem_Addr holds BASE_ADDR + 4*DEPTH (one past the end) and no strobe is issued. The pointer never wraps.
- Err persists across subsequent legal writes until Clear or reset.
- Mem_Addr and Mem_Write_Data hold their last values outside WRITE. Consumers qualify them with Mem_Write_En only.

Decomposition:
- Shared package mips_isa_pkg holds:
  - the Op_Sel enum;
  - 6-bit opcode localparams shared with the control decoder (OPC_RTYPE, OPC_LW, ... OPC_SH);
  - the field bit positions (31:26, 25:21, 20:16, 15:11, 10:6, 5:0).
- One sub-module: instr_word_pack. It is purely combinational: Op_Sel plus fields in, {word, illegal} out. It is instantiated once and registered in ENCODE. The FSM, pointer and counters stay in instr_encoder.

Test Plan:
- Reset with BASE_ADDR=0; ADDI, Rs=0, Rt=8, Imm=5 → at T+2 Mem_Write_En=1, Mem_Addr=0x0, Mem_Write_Data=0x20080005; Word_Count=1.
- RTYPE Rs=8, Rt=9, Rd=10, Shamt=0, Funct=0x20, then LW Rs=8, Rt=9, Imm=4 → writes 0x01095020 at 0x0, then 0x8D090004 at 0x4. In_Ready low for exactly 2 cycles after each acceptance.
- J Target=0x10 → 0x08000010. LUI Rs=7, Rt=8, Imm=0x1234 → 0x3C081234 (Rs ignored).
- Op_Sel=20 → no strobe, Err=1, Mem_Addr unchanged. A following ORI Rt=1, Imm=0xFF → 0x340100FF written, Err still 1. Clear → Err=0, Word_Count=0, Mem_Addr=BASE_ADDR.
- DEPTH=4: 4 legal writes → Full=1, In_Ready=0. A 5th In_Valid held 10 cycles → no strobe. Clear → In_Ready=1, next write at BASE_ADDR.
- Rst_N or Clear asserted in the ENCODE cycle → no Mem_Write_En in the following cycle, all outputs at reset values, In_Ready=1 after release.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: operation select codes, 6-bit opcodes and
// instruction field positions, common to the control decoder and the encoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_RTYPE = 5'd0,
    OP_LW    = 5'd1,
    OP_SW    = 5'd2,
    OP_ADDI  = 5'd3,
    OP_ANDI  = 5'd4,
    OP_ORI   = 5'd5,
    OP_SLTI  = 5'd6,
    OP_XORI  = 5'd7,
    OP_BNE   = 5'd8,
    OP_BEQ   = 5'd9,
    OP_J     = 5'd10,
    OP_JAL   = 5'd11,
    OP_LUI   = 5'd12,
    OP_LB    = 5'd13,
    OP_LH    = 5'd14,
    OP_SB    = 5'd15,
    OP_SH    = 5'd16
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_JAL   = 6'd3;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_BNE   = 6'd5;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_SLTI  = 6'd10;
  localparam logic [5:0] OPC_ANDI  = 6'd12;
  localparam logic [5:0] OPC_ORI   = 6'd13;
  localparam logic [5:0] OPC_XORI  = 6'd14;
  localparam logic [5:0] OPC_LUI   = 6'd15;
  localparam logic [5:0] OPC_LB    = 6'd32;
  localparam logic [5:0] OPC_LH    = 6'd33;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SB    = 6'd40;
  localparam logic [5:0] OPC_SH    = 6'd41;
  localparam logic [5:0] OPC_SW    = 6'd43;

  localparam int OPC_HI = 31, OPC_LO = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int TGT_HI = 25, TGT_LO = 0;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  // Returns {is_itype, opcode}; is_itype is 0 for RTYPE, J-type and illegal codes.
  function automatic logic [6:0] itype_opcode(input logic [4:0] op);
    case (op)
      OP_LW:   return {1'b1, OPC_LW};
      OP_SW:   return {1'b1, OPC_SW};
      OP_ADDI: return {1'b1, OPC_ADDI};
      OP_ANDI: return {1'b1, OPC_ANDI};
      OP_ORI:  return {1'b1, OPC_ORI};
      OP_SLTI: return {1'b1, OPC_SLTI};
      OP_XORI: return {1'b1, OPC_XORI};
      OP_BNE:  return {1'b1, OPC_BNE};
      OP_BEQ:  return {1'b1, OPC_BEQ};
      OP_LUI:  return {1'b1, OPC_LUI};
      OP_LB:   return {1'b1, OPC_LB};
      OP_LH:   return {1'b1, OPC_LH};
      OP_SB:   return {1'b1, OPC_SB};
      OP_SH:   return {1'b1, OPC_SH};
      default: return {1'b0, OPC_RTYPE};
    endcase
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: operation select plus decoded fields into one
// 32-bit MIPS instruction word, flagging operation codes with no encoding.
module instr_word_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]    op_sel,
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          illegal
);

  logic [6:0] iop;

  assign iop = itype_opcode(op_sel);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (op_sel == OP_RTYPE) begin
      word[OPC_HI:OPC_LO] = OPC_RTYPE;
      word[RS_HI:RS_LO]   = fields.rs;
      word[RT_HI:RT_LO]   = fields.rt;
      word[RD_HI:RD_LO]   = fields.rd;
      word[SH_HI:SH_LO]   = fields.shamt;
      word[FN_HI:FN_LO]   = fields.funct;
    end else if (op_sel == OP_J || op_sel == OP_JAL) begin
      word[OPC_HI:OPC_LO] = (op_sel == OP_J) ? OPC_J : OPC_JAL;
      word[TGT_HI:TGT_LO] = fields.target;
    end else if (iop[6]) begin
      word[OPC_HI:OPC_LO] = iop[5:0];
      // LUI has no source register; the Rs slot is architecturally zero.
      word[RS_HI:RS_LO]   = (op_sel == OP_LUI) ? 5'd0 : fields.rs;
      word[RT_HI:RT_LO]   = fields.rt;
      word[IMM_HI:IMM_LO] = fields.imm;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded instruction fields, packs them into MIPS
// words and writes them sequentially into instruction memory.
//
// state     | meaning
// ST_IDLE   | waiting for fields; ready unless memory is full
// ST_ENCODE | captured fields packed into the write data register
// ST_WRITE  | one-cycle write strobe, then pointer and count advance
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         Clk,
  input  logic                         Rst_N,
  input  logic                         Clear,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [4:0]                   Op_Sel,
  input  logic [4:0]                   Rs,
  input  logic [4:0]                   Rt,
  input  logic [4:0]                   Rd,
  input  logic [4:0]                   Shamt,
  input  logic [5:0]                   Funct,
  input  logic [15:0]                  Imm,
  input  logic [25:0]                  Target,
  output logic                         Mem_Write_En,
  output logic [ADDR_W-1:0]            Mem_Addr,
  output logic [31:0]                  Mem_Write_Data,
  output logic [$clog2(DEPTH+1)-1:0]   Word_Count,
  output logic                         Full,
  output logic                         Err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENCODE = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        op_sel_q, op_sel_d;
  instr_fields_t     fields_q, fields_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        full;
  logic        active;

  instr_word_pack u_pack (
    .op_sel  (op_sel_q),
    .fields  (fields_q),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign full   = (count_q == CNT_W'(DEPTH));
  // Reset or Clear in progress: no handshake and no strobe this cycle.
  assign active = Rst_N && !Clear;

  assign In_Ready       = active && (state_q == ST_IDLE) && !full;
  assign Mem_Write_En   = active && (state_q == ST_WRITE);
  assign Mem_Addr       = addr_q;
  assign Mem_Write_Data = data_q;
  assign Word_Count     = count_q;
  assign Full           = full;
  assign Err            = err_q;

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    fields_d = fields_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (In_Valid && In_Ready) begin
          op_sel_d        = Op_Sel;
          fields_d.rs     = Rs;
          fields_d.rt     = Rt;
          fields_d.rd     = Rd;
          fields_d.shamt  = Shamt;
          fields_d.funct  = Funct;
          fields_d.imm    = Imm;
          fields_d.target = Target;
          state_d         = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (pack_illegal) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          data_d  = pack_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (Clear) begin
      state_d  = ST_IDLE;
      op_sel_d = '0;
      fields_d = '0;
      addr_d   = BASE_ADDR;
      data_d   = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      state_q  <= ST_IDLE;
      op_sel_q <= '0;
      fields_q <= '0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      fields_q <= fields_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, abort and
// full-memory sequences, then randomized traffic against a reference model.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        Clk, Rst_N, Clear, In_Valid, In_Ready;
  logic [4:0]  Op_Sel, Rs, Rt, Rd, Shamt;
  logic [5:0]  Funct;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        Mem_Write_En, Full, Err;
  logic [31:0] Mem_Addr, Mem_Write_Data;
  logic [2:0]  Word_Count;

  instr_encoder #(.ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .Clear(Clear), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Op_Sel(Op_Sel), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Imm(Imm), .Target(Target), .Mem_Write_En(Mem_Write_En), .Mem_Addr(Mem_Addr),
    .Mem_Write_Data(Mem_Write_Data), .Word_Count(Word_Count), .Full(Full), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp_word;
    bit          exp_ill;
    bit          clr;
  } vec_t;

  // Opcode for each Op_Sel value 0..16, straight from the ISA opcode map.
  localparam int unsigned OPC_TBL [0:16] =
    '{0, 35, 43, 8, 12, 13, 10, 14, 5, 4, 2, 3, 15, 32, 33, 40, 41};

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_addr;
  int          m_count;
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [32:0] ref_encode(input vec_t v);
    logic [31:0] w;
    int unsigned opc;
    if (v.op > 5'd16) return {1'b1, 32'h0};
    opc = OPC_TBL[v.op];
    if (v.op == 5'd0)
      w = (32'(v.rs) << 21) | (32'(v.rt) << 16) | (32'(v.rd) << 11) | (32'(v.sh) << 6) | 32'(v.fn);
    else if (v.op == 5'd10 || v.op == 5'd11)
      w = (opc << 26) | 32'(v.tgt);
    else
      w = (opc << 26) | ((v.op == 5'd12) ? 32'h0 : (32'(v.rs) << 21)) | (32'(v.rt) << 16) | 32'(v.imm);
    return {1'b0, w};
  endfunction

  task automatic drive(input vec_t v);
    Op_Sel = v.op; Rs = v.rs; Rt = v.rt; Rd = v.rd; Shamt = v.sh;
    Funct = v.fn; Imm = v.imm; Target = v.tgt;
  endtask

  task automatic scramble();
    Op_Sel = 5'($urandom); Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
    Shamt = 5'($urandom); Funct = 6'($urandom); Imm = 16'($urandom); Target = 26'($urandom);
  endtask

  task automatic model_reset();
    m_addr = BASE; m_count = 0; m_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_strobe"}, 32'(Mem_Write_En), 32'd0);
    check({tag, "_addr"},   Mem_Addr, BASE);
    check({tag, "_data"},   Mem_Write_Data, 32'h0);
    check({tag, "_count"},  32'(Word_Count), 32'd0);
    check({tag, "_full"},   32'(Full), 32'd0);
    check({tag, "_err"},    32'(Err), 32'd0);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    #1;
    check_reset_values("clear");
    check("clear_ready", 32'(In_Ready), 32'd1);
    model_reset();
  endtask

  // One full transaction from acceptance through the write (or illegal drop).
  task automatic send(input vec_t v);
    check("ready_idle", 32'(In_Ready), 32'd1);
    drive(v);
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    scramble();
    check("ready_encode", 32'(In_Ready), 32'd0);
    check("strobe_encode", 32'(Mem_Write_En), 32'd0);
    step();
    if (v.exp_ill) begin
      m_err = 1'b1;
      check("ill_strobe", 32'(Mem_Write_En), 32'd0);
      check("ill_err", 32'(Err), 32'd1);
      check("ill_addr", Mem_Addr, m_addr);
      check("ill_count", 32'(Word_Count), 32'(m_count));
      check("ill_ready", 32'(In_Ready), 32'd1);
    end else begin
      check("wr_strobe", 32'(Mem_Write_En), 32'd1);
      check("wr_addr", Mem_Addr, m_addr);
      check("wr_data", Mem_Write_Data, v.exp_word);
      check("wr_ready", 32'(In_Ready), 32'd0);
      step();
      m_addr  = m_addr + 32'd4;
      m_count = m_count + 1;
      check("post_strobe", 32'(Mem_Write_En), 32'd0);
      check("post_count", 32'(Word_Count), 32'(m_count));
      check("post_addr", Mem_Addr, m_addr);
      check("post_full", 32'(Full), 32'(m_count == DEPTH));
      check("post_ready", 32'(In_Ready), 32'(m_count != DEPTH));
      check("post_err", 32'(Err), 32'(m_err));
    end
  endtask

  task automatic hold_while_full(input int cycles);
    In_Valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      step();
      check("full_strobe", 32'(Mem_Write_En), 32'd0);
      check("full_ready", 32'(In_Ready), 32'd0);
      check("full_addr", Mem_Addr, BASE + 32'(4 * DEPTH));
      check("full_count", 32'(Word_Count), 32'(DEPTH));
    end
    In_Valid = 1'b0;
  endtask

  vec_t tbl [7];
  vec_t v;
  logic [32:0] r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     rs     rt     rd      sh    fn      imm       tgt        exp_word     ill  clr
    tbl[0] = '{5'd3,  5'd0,  5'd8,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0,    32'h20080005, 1'b0, 1'b0};
    tbl[1] = '{5'd0,  5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'hBEEF, 26'h3FF,  32'h01095020, 1'b0, 1'b1};
    tbl[2] = '{5'd1,  5'd8,  5'd9,  5'd3,  5'd7, 6'h11, 16'h0004, 26'h0,    32'h8D090004, 1'b0, 1'b0};
    tbl[3] = '{5'd10, 5'd5,  5'd6,  5'd7,  5'd1, 6'h01, 16'h1111, 26'h10,   32'h08000010, 1'b0, 1'b0};
    tbl[4] = '{5'd12, 5'd7,  5'd8,  5'd0,  5'd0, 6'h00, 16'h1234, 26'h0,    32'h3C081234, 1'b0, 1'b1};
    tbl[5] = '{5'd20, 5'd1,  5'd2,  5'd3,  5'd4, 6'h05, 16'h0006, 26'h7,    32'h0,        1'b1, 1'b0};
    tbl[6] = '{5'd5,  5'd0,  5'd1,  5'd0,  5'd0, 6'h00, 16'h00FF, 26'h0,    32'h340100FF, 1'b0, 1'b0};

    Rst_N = 1'b0; Clear = 1'b0; In_Valid = 1'b0;
    scramble();
    model_reset();
    step();
    step();
    check("rst_ready_low", 32'(In_Ready), 32'd0);
    check_reset_values("rst");
    Rst_N = 1'b1;
    #1;
    check("rst_ready_high", 32'(In_Ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr || m_count == DEPTH) do_clear();
      send(tbl[i]);
    end
    do_clear();

    // Fill memory, then a held request must be ignored without error.
    for (int i = 0; i < DEPTH; i++) send(tbl[6]);
    check("full_flag", 32'(Full), 32'd1);
    hold_while_full(10);
    check("full_no_err", 32'(Err), 32'd0);
    do_clear();
    send(tbl[0]);
    check("after_full_addr", Mem_Addr, BASE + 32'd4);

    // Clear during ENCODE aborts the pending write.
    drive(tbl[2]);
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    #1;
    check_reset_values("clr_enc");
    check("clr_enc_ready", 32'(In_Ready), 32'd1);
    model_reset();

    send(tbl[3]);
    // Reset during ENCODE aborts the pending write.
    drive(tbl[2]);
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    Rst_N = 1'b0;
    step();
    check_reset_values("rst_enc");
    check("rst_enc_ready", 32'(In_Ready), 32'd0);
    Rst_N = 1'b1;
    #1;
    check("rst_enc_ready_rel", 32'(In_Ready), 32'd1);
    model_reset();

    for (int i = 0; i < 60; i++) begin
      if (m_count == DEPTH) begin
        hold_while_full(3);
        do_clear();
      end else if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end
      v.op  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      v.rs  = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom); v.sh = 5'($urandom);
      v.fn  = 6'($urandom); v.imm = 16'($urandom); v.tgt = 26'($urandom);
      v.clr = 1'b0;
      r = ref_encode(v);
      v.exp_word = r[31:0];
      v.exp_ill  = r[32];
      send(v);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        check("gap_strobe", 32'(Mem_Write_En), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
